// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential divider.
package div_pkg;
    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;
endpackage

// File: rtl/div_addsub.sv
// (WIDTH+1)-bit add/subtract step for the non-restoring divider.
module div_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum
);
    assign sum = sub ? (a - b) : (a + b);
endmodule

// File: rtl/seq_divider.sv
// Sequential non-restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands and results.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg, d_reg;

    logic [WIDTH:0]   p_shift, p_step;
    logic [WIDTH-1:0] q_step;
    logic             neg_a, neg_b, overflow;
    logic [WIDTH-1:0] mag_a, mag_b, rem_mag;
    logic [WIDTH-1:0] res_q, res_r;
    logic             res_dz;

    assign ready = (state == S_IDLE) || (state == S_DONE);
    assign done  = (state == S_DONE);

    // Decision uses the sign of P before the shift; the shifted-in bit is the next dividend bit.
    assign p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign q_step  = {q_reg[WIDTH-2:0], ~p_step[WIDTH]};

    div_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (p_shift),
        .b   ({1'b0, d_reg}),
        .sub (~p_reg[WIDTH]),
        .sum (p_step)
    );

    always_comb begin
        neg_a    = 1'b0;
        neg_b    = 1'b0;
        overflow = 1'b0;
        mag_a    = op_a;
        mag_b    = op_b;
`ifdef DIV_SIGNED_EN
        neg_a    = op_a[WIDTH-1];
        neg_b    = op_b[WIDTH-1];
        mag_a    = neg_a ? (~op_a + 1'b1) : op_a;
        mag_b    = neg_b ? (~op_b + 1'b1) : op_b;
        overflow = (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == {WIDTH{1'b1}});
`endif
    end

    // Final correction: remainder is non-negative and below the divisor, so W bits suffice.
    always_comb begin
        rem_mag = p_reg[WIDTH] ? (p_reg[WIDTH-1:0] + d_reg) : p_reg[WIDTH-1:0];
        res_q   = (neg_a ^ neg_b) ? (~q_reg + 1'b1) : q_reg;
        res_r   = neg_a ? (~rem_mag + 1'b1) : rem_mag;
        res_dz  = 1'b0;
        if (d_reg == '0) begin
            res_q  = '1;
            res_r  = op_a;
            res_dz = 1'b1;
        end else if (overflow) begin
            res_q = op_a;
            res_r = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_PREP;
            S_PREP:  state_nxt = S_ITER;
            S_ITER:  if (count == '0) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_PREP : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_PREP) count <= CNT_W'(WIDTH - 1);
            else if (state == S_ITER) count <= count - 1'b1;
            if (state == S_FIX) begin
                quotient    <= res_q;
                remainder   <= res_r;
                div_by_zero <= res_dz;
            end
        end
    end

    // Datapath registers carry no reset; control decides when they are meaningful.
    always_ff @(posedge clk) begin
        if (ready && start) begin
            op_a <= dividend;
            op_b <= divisor;
        end
        if (state == S_PREP) begin
            p_reg <= '0;
            q_reg <= mag_a;
            d_reg <= mag_b;
        end else if (state == S_ITER) begin
            p_reg <= p_step;
            q_reg <= q_step;
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider; expectations follow DIV_SIGNED_EN.
module tb_seq_divider;
    localparam int W   = 16;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pushes = 0;
    int   dones  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            dones++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                chk("latency", 32'(cyc - e.acc), 32'(LAT));
                chk("ready_in_done", 32'(ready), 32'd1);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; start is sampled by the next posedge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                          input logic [W-1:0] r, input logic dz, input bit push);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) begin
            e.q = q; e.r = r; e.dz = dz; e.acc = cyc + 1;
            sb.push_back(e);
            pushes++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                         input logic [W-1:0] r, input logic dz, input bit push);
        @(negedge clk);
        wait_ready();
        launch(a, b, q, r, dz, push);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
        drain();
`ifdef DIV_SIGNED_EN
        issue(16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b1);
        issue(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1);
        issue(16'hFFFF, 16'd2, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
        issue(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, 1'b1);
`else
        issue(16'hFFFF, 16'd2, 16'h7FFF, 16'd1, 1'b0, 1'b1);
        issue(16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b1);
        issue(16'hFF9C, 16'd7, 16'd9348, 16'd0, 1'b0, 1'b1);
`endif
        drain();
        issue(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1'b1);
        issue(16'hFFF9, 16'd0, 16'hFFFF, 16'hFFF9, 1'b1, 1'b1);
        drain();

        // Starts during an operation must be ignored.
        issue(16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("busy_ready", 32'(ready), 32'd0);
        launch(16'd1000, 16'd1, 16'd0, 16'd0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        launch(16'd1234, 16'd5, 16'd0, 16'd0, 1'b0, 1'b0);
        // New start in the done cycle is accepted.
        wait_done();
        launch(16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 1'b1);
        drain();

        // Asynchronous reset mid-iteration discards the operation.
        issue(16'd1000, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b1);
        drain();
        repeat (25) @(negedge clk);

        chk("done_count", 32'(dones), 32'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
